// File: rtl/uio_arb_pkg.sv
// Shared types and width helpers for the uio pad-bank arbiter.
// Imported by the selector and the top-level FSM.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } arb_state_e;

  // Turnaround length is bounded to 0..7 cycles.
  localparam int unsigned TurnW = 3;

  // Index width for a requester vector; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value m itself.
  function automatic int unsigned cnt_w(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side handshake and uio pad signals shared by the arbiter and its users.
// master = requesters/pads side, slave = arbiter side.
interface uio_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();

  logic               ena;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   dir;
  logic [N_REQ-1:0]   last;
  logic [N_REQ*8-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [7:0]         rdata;
  logic               busy;
  logic [7:0]         uio_in;
  logic [7:0]         uio_out;
  logic [7:0]         uio_oe;

  modport master (
    output ena, req, dir, last, wdata, uio_in,
    input  gnt, rdata, busy, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, dir, last, wdata, uio_in,
    output gnt, rdata, busy, uio_out, uio_oe
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping modulo N_REQ.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [idx_w(N_REQ)-1:0]  ptr,
  output logic [N_REQ-1:0]         onehot,
  output logic [idx_w(N_REQ)-1:0]  idx,
  output logic                     any
);

  localparam int unsigned IdxW = idx_w(N_REQ);

  int unsigned     cand;
  logic [IdxW-1:0] ci;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    ci     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      ci   = IdxW'(cand);
      if (!any && req[ci]) begin
        any        = 1'b1;
        onehot[ci] = 1'b1;
        idx        = ci;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bank: bounded bursts, registered pad drive/capture,
// and a quiet turnaround between owners so two drivers never overlap.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input logic              clk,
  input logic              rst_n,
  uio_bus_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = idx_w(N_REQ);
  localparam int unsigned BeatW = cnt_w(MAX_BURST);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IdxW-1:0]  gidx_q;
  logic [IdxW-1:0]  rr_ptr_q;
  logic             dir_q;
  logic [BeatW-1:0] beat_q;
  logic [TurnW-1:0] turn_q;
  logic [7:0]       uio_out_q;
  logic [7:0]       uio_oe_q;
  logic [7:0]       rdata_q;

  logic [N_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  logic            req_g;
  logic            last_g;
  logic            burst_full;
  logic            grant_end;
  logic [IdxW-1:0] ptr_after;

  always_comb begin
    req_g      = bus.req[gidx_q];
    last_g     = bus.last[gidx_q];
    // The beat happening now is the MAX_BURST-th one.
    burst_full = (beat_q == BeatW'(MAX_BURST - 1));
    grant_end  = !req_g || last_g || burst_full;
    ptr_after  = (gidx_q == IdxW'(N_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      dir_q     <= 1'b0;
      beat_q    <= '0;
      turn_q    <= '0;
      uio_out_q <= '0;
      uio_oe_q  <= '0;
      rdata_q   <= '0;
    end else if (!bus.ena) begin
      // Abort: park the bus; uio_out and rdata keep their last values.
      state_q  <= StIdle;
      gnt_q    <= '0;
      uio_oe_q <= '0;
      beat_q   <= '0;
      turn_q   <= '0;
      if (state_q == StGrant) rr_ptr_q <= ptr_after;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q  <= StGrant;
            gnt_q    <= pick_onehot;
            gidx_q   <= pick_idx;
            dir_q    <= bus.dir[pick_idx];
            uio_oe_q <= {8{bus.dir[pick_idx]}};
            beat_q   <= '0;
          end
        end
        StGrant: begin
          if (req_g) begin
            if (dir_q) uio_out_q <= bus.wdata[{gidx_q, 3'b000} +: 8];
            else       rdata_q   <= bus.uio_in;
            beat_q <= beat_q + BeatW'(1);
          end
          if (grant_end) begin
            state_q  <= (TURNAROUND > 0) ? StTurn : StIdle;
            gnt_q    <= '0;
            uio_oe_q <= '0;
            beat_q   <= '0;
            turn_q   <= '0;
            rr_ptr_q <= ptr_after;
          end
        end
        StTurn: begin
          if (turn_q == TurnW'(TURNAROUND - 1)) state_q <= StIdle;
          else                                  turn_q  <= turn_q + TurnW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != StIdle);

endmodule
